// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-style SDRAM master port between three
// frame-buffer clients (0 = capture write, 1 = display read, 2 = analysis).
// Bursts are granted by fixed priority with an anti-starvation override.
// Returning read words are routed to their issuer through an in-order tag FIFO.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int BURST_MAX  = 16,
    parameter int STARVE_LIM = 64,
    parameter int PEND_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr_flat,
    input  logic [47:0]           wdata_flat,
    output logic [2:0]            ack,
    output logic [2:0]            rvalid,
    output logic [15:0]           rdata,
    input  logic                  sd_wait_rq,
    input  logic [15:0]           sd_rdata,
    input  logic                  sd_rdata_valid,
    output logic [ADDR_W-1:0]     sd_addr,
    output logic [1:0]            sd_byte_en_n,
    output logic [15:0]           sd_data,
    output logic                  sd_read_n,
    output logic                  sd_write_n,
    output logic [1:0]            owner_out,
    output logic                  err
);
    localparam int PTR_W   = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);
    localparam logic [7:0]         STARVE_C  = 8'(STARVE_LIM);
    localparam logic [PTR_W:0]     DEPTH_C   = (PTR_W + 1)'(PEND_DEPTH);
    localparam logic [1:0]         NO_OWNER  = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [7:0]          starve_q [3];
    logic [1:0]          tag_q [PEND_DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, rdPtr_q;
    logic [PTR_W:0]      count_q;
    logic [ADDR_W-1:0]   sdAddr_q;
    logic [15:0]         sdData_q;
    logic                sdReadN_q, sdWriteN_q;
    logic [2:0]          rvalid_q;
    logic [15:0]         rdata_q;
    logic                err_q;

    logic                cmdPending, fifoFull, fifoEmpty;
    logic                grant, ackAny, push, pop;
    logic                ownerReq, ownerWe;
    logic [1:0]          winner;
    logic [ADDR_W-1:0]   selAddr;
    logic [15:0]         selData;

    assign cmdPending = !sdReadN_q || !sdWriteN_q;
    assign fifoFull   = (count_q == DEPTH_C);
    assign fifoEmpty  = (count_q == '0);
    assign grant      = (state_q == IDLE) && (|req);
    assign push       = ackAny && !ownerWe;
    assign pop        = sd_rdata_valid && !fifoEmpty;

    // Pick the next owner: lowest starved requester first, else lowest requester.
    always_comb begin
        winner = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
        for (int i = 2; i >= 0; i--) begin
            if (req[i] && (starve_q[i] >= STARVE_C)) winner = 2'(i);
        end
    end

    // Grant FSM next state, owner's command acknowledge and burst counting.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        ack      = 3'b000;
        ackAny   = 1'b0;
        ownerReq = 1'b0;
        ownerWe  = 1'b0;
        selAddr  = '0;
        selData  = '0;
        case (owner_q)
            2'd0: begin
                ownerReq = req[0];
                ownerWe  = we[0];
                selAddr  = addr_flat[0 +: ADDR_W];
                selData  = wdata_flat[0 +: 16];
            end
            2'd1: begin
                ownerReq = req[1];
                ownerWe  = we[1];
                selAddr  = addr_flat[ADDR_W +: ADDR_W];
                selData  = wdata_flat[16 +: 16];
            end
            2'd2: begin
                ownerReq = req[2];
                ownerWe  = we[2];
                selAddr  = addr_flat[2*ADDR_W +: ADDR_W];
                selData  = wdata_flat[32 +: 16];
            end
            default: ;
        endcase
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    burst_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                ackAny = ownerReq && (!cmdPending || !sd_wait_rq) &&
                         (burst_q < BURST_LIM) && (ownerWe || !fifoFull);
                if (ackAny) begin
                    ack     = 3'b001 << owner_q;
                    burst_d = burst_q + 1'b1;
                end
                if (!ownerReq || (burst_d == BURST_LIM) || (!ownerWe && fifoFull)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!cmdPending) begin
                    state_d = IDLE;
                    owner_d = NO_OWNER;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NO_OWNER;
            end
        endcase
    end

    // FSM state, owner and burst count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= NO_OWNER;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // Saturating wait counters; a client's counter clears when it wins a grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) starve_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (grant && (winner == 2'(i))) begin
                    starve_q[i] <= 8'd0;
                end else if (req[i] && (owner_q != 2'(i)) && (starve_q[i] != 8'hFF)) begin
                    starve_q[i] <= starve_q[i] + 8'd1;
                end
            end
        end
    end

    // Bus command register: load on ack, hold while stalled, release once accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdAddr_q   <= '0;
            sdData_q   <= '0;
            sdReadN_q  <= 1'b1;
            sdWriteN_q <= 1'b1;
        end else if (ackAny) begin
            sdAddr_q   <= selAddr;
            sdData_q   <= selData;
            sdReadN_q  <= ownerWe;
            sdWriteN_q <= !ownerWe;
        end else if (cmdPending && !sd_wait_rq) begin
            sdReadN_q  <= 1'b1;
            sdWriteN_q <= 1'b1;
        end
    end

    // In-order tag FIFO recording which client issued each outstanding read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) tag_q[i] <= 2'd0;
        end else begin
            if (push) begin
                tag_q[wrPtr_q] <= owner_q;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop) rdPtr_q <= rdPtr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Read return path and sticky error for data arriving with no read outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 3'b000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= pop ? (3'b001 << tag_q[rdPtr_q]) : 3'b000;
            if (pop) rdata_q <= sd_rdata;
            if (sd_rdata_valid && fifoEmpty) err_q <= 1'b1;
        end
    end

    assign sd_addr      = sdAddr_q;
    assign sd_data      = sdData_q;
    assign sd_read_n    = sdReadN_q;
    assign sd_write_n   = sdWriteN_q;
    assign sd_byte_en_n = 2'b00;
    assign owner_out    = owner_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign err          = err_q;
endmodule
